// File: rtl/freq_mag_reader.sv
// Sweeps the sliding-DFT frequency-bin BRAMs and streams re^2+im^2 per bin
// to a valid/ready sink, one bin every four cycles when the sink never stalls.
module freq_mag_reader #(
    parameter int data_w   = 20,
    parameter int addr_w   = 7,
    parameter int num_bins = 2**addr_w
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       r_en,
    output logic [addr_w-1:0]          r_addr,
    input  logic signed [data_w-1:0]   re_in,
    input  logic signed [data_w-1:0]   im_in,
    output logic [2*data_w-1:0]        mag_out,
    output logic [addr_w-1:0]          mag_addr,
    output logic                       mag_valid,
    input  logic                       mag_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        SUM   = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [addr_w-1:0] last_bin = addr_w'(num_bins - 1);

    state_t                state_r;
    state_t                next_state_s;
    logic [addr_w-1:0]     k_r;
    logic [addr_w-1:0]     k_next_s;
    logic                  handshake_s;
    logic signed [2*data_w-1:0] prod_re_s;
    logic signed [2*data_w-1:0] prod_im_s;
    logic [2*data_w-1:0]   sq_re_r;
    logic [2*data_w-1:0]   sq_im_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  r_en_r;
    logic [addr_w-1:0]     r_addr_r;
    logic [2*data_w-1:0]   mag_out_r;
    logic [addr_w-1:0]     mag_addr_r;
    logic                  mag_valid_r;

    assign handshake_s = mag_valid_r && mag_ready;
    // Squares of a signed value are non-negative and fit in 2*data_w-1 bits.
    assign prod_re_s   = re_in * re_in;
    assign prod_im_s   = im_in * im_in;

    // Next-state and bin-counter logic.
    always_comb begin
        next_state_s = state_r;
        k_next_s     = k_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = READ;
                    k_next_s     = {addr_w{1'b0}};
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ:  next_state_s = LATCH;
            LATCH: next_state_s = SUM;
            SUM:   next_state_s = OUT;
            OUT: begin
                if (handshake_s) begin
                    if (k_r == last_bin) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = READ;
                        k_next_s     = k_r + addr_w'(1);
                    end
                end else begin
                    next_state_s = OUT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State and bin-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            k_r     <= {addr_w{1'b0}};
        end else begin
            state_r <= next_state_s;
            k_r     <= k_next_s;
        end
    end

    // Registered outputs decoded from the next state, plus the datapath.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            r_en_r      <= 1'b0;
            r_addr_r    <= {addr_w{1'b0}};
            sq_re_r     <= {(2*data_w){1'b0}};
            sq_im_r     <= {(2*data_w){1'b0}};
            mag_out_r   <= {(2*data_w){1'b0}};
            mag_addr_r  <= {addr_w{1'b0}};
            mag_valid_r <= 1'b0;
        end else begin
            busy_r      <= (next_state_s == READ) || (next_state_s == LATCH) ||
                           (next_state_s == SUM)  || (next_state_s == OUT);
            done_r      <= (next_state_s == DONE);
            r_en_r      <= (next_state_s == READ);
            mag_valid_r <= (next_state_s == OUT);
            // r_addr only moves when a read is issued, so it holds between reads.
            if (next_state_s == READ) begin
                r_addr_r <= k_next_s;
            end
            if (state_r == LATCH) begin
                sq_re_r <= prod_re_s;
                sq_im_r <= prod_im_s;
            end
            if (state_r == SUM) begin
                mag_out_r  <= sq_re_r + sq_im_r;
                mag_addr_r <= k_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign r_en      = r_en_r;
    assign r_addr    = r_addr_r;
    assign mag_out   = mag_out_r;
    assign mag_addr  = mag_addr_r;
    assign mag_valid = mag_valid_r;

endmodule
